fifo_read_packer: RTL and testbench
===================================

Name: fifo_read_packer

Overview:
- Downstream consumer of the access-enable FIFO.
- Pops WIDTH-bit words through the FIFO read interface (empty / read_enable / read_data) and packs RATIO consecutive words into one wide beat on a valid/ready output stream.
- A flush input closes a partial packet early; a keep mask marks the valid slots.
- Bridges byte-level FIFO buffering to wide datapaths such as bus masters and DMA write ports.

Parameters:
- WIDTH, 8, width of one FIFO word.
- RATIO, 4, FIFO words per output packet (≥2).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_read_enable  output  1  pop request to the FIFO, combinational.
- fifo_read_data  input  WIDTH  FIFO head word; valid in the same cycle whenever fifo_empty=0 (unregistered read).
- flush  input  1  close the current partial packet.
- out_valid  output  1  packet available.
- out_ready  input  1  downstream accepts the packet.
- out_data  output  WIDTH*RATIO  packed data; slot i occupies bits [i*WIDTH +: WIDTH]; the first word popped lands in slot 0.
- out_keep  output  RATIO  bit i=1 when slot i holds valid data.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset, sampled on the clock edge:
  - out_valid=0, out_data=0, out_keep=0, slot index=0.
  - fifo_read_enable forced 0 while reset=1.
  - A partial packet in progress is discarded; no FIFO word is consumed in the reset cycle.
- State FILLING (out_valid=0); the slot index counts 0..RATIO-1, register width CLOG2(RATIO+1).
- State HOLDING (out_valid=1); out_data and out_keep are held stable until the handshake.
- drain = out_valid & out_ready.
- fifo_read_enable = !reset & !fifo_empty & (!out_valid | drain).
- Pop cycle: fifo_read_data is written into slot[index] and out_keep[index] is set.
  - index=RATIO-1 → go to HOLDING, index←0. out_valid rises the cycle after the last pop (latency 1).
  - Otherwise index increments.
- Drain cycle:
  - out_valid falls unless a new packet completes in the same cycle.
  - All slots and the keep mask clear, except the slot written by a same-cycle pop.
  - A pop in the drain cycle writes slot 0, so back-to-back operation needs no bubble.
- Flush, sampled in FILLING only:
  - Words already captured plus any same-cycle pop ≥1 → go to HOLDING with a partial keep mask (e.g. 0011); unfilled slots are 0; index←0.
  - Nothing captured and no pop → no effect.
  - Flush in HOLDING is ignored; it is not queued.
- Flush while the pop fills the last slot → normal full packet, keep=all ones.
- Throughput: with out_ready held high and the FIFO never empty, one packet every RATIO cycles with fifo_read_enable continuously high.
- Backpressure: out_ready=0 in HOLDING stalls popping; the FIFO absorbs the backlog.
- Empty FIFO: fifo_read_enable=0; the partial packet is retained indefinitely (no timeout).
- fifo_read_enable must never assert when fifo_empty=1. The bench flags any underflow.
- out_data and out_keep must not change while out_valid=1 and out_ready=0.

Test Plan (WIDTH=8, RATIO=4):
1. Reset, then push 11,22,33,44 into the FIFO with out_ready=1 → exactly 4 pops; out_valid=1 one cycle after the 4th pop; out_data=0x44332211, out_keep=1111; out_valid=0 the next cycle.
2. Stream 12 words 01..0C continuously with out_ready=1 → packets 0x04030201, 0x08070605, 0x0C0B0A09; fifo_read_enable high for 12 consecutive cycles; no bubble at packet boundaries.
3. Complete a packet with out_ready=0 for 5 cycles while the FIFO holds 3 more words → no pops during the stall; out_data stable; on the ready cycle the packet drains and slot 0 is filled in that same cycle.
4. Push A1,A2, then assert flush with the FIFO empty → out_data=0x0000A2A1, out_keep=0011. Flush with index=0 and the FIFO empty → out_valid stays 0.
5. Flush asserted in the same cycle as the pop of the 3rd word B3 (after B1,B2) → out_data=0x00B3B2B1, out_keep=0111. Flush coincident with the 4th pop → keep=1111.
6. Reset asserted after 2 words captured, FIFO non-empty → fifo_read_enable=0 in the reset cycle; after reset the next 4 FIFO words form a clean packet with no stale bytes.

Source files
------------

// File: rtl/fifo_read_packer.sv
// fifo_read_packer
//
// Pops WIDTH-bit words from a FIFO with an unregistered (show-ahead) read
// port and packs RATIO consecutive words into one wide beat on a
// valid/ready output stream. A flush closes a partial packet early and
// out_keep marks which slots hold captured words.
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous, active-high reset
//   fifo_empty       FIFO empty flag
//   fifo_read_enable pop request to the FIFO (combinational)
//   fifo_read_data   FIFO head word, valid whenever fifo_empty=0
//   flush            close the current partial packet
//   out_valid        packet available
//   out_ready        downstream accepts the packet
//   out_data         packed data; slot i at [i*WIDTH +: WIDTH], first word in slot 0
//   out_keep         bit i set when slot i holds valid data
module fifo_read_packer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fifo_empty,
    output logic                     fifo_read_enable,
    input  logic [WIDTH-1:0]         fifo_read_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*RATIO-1:0]   out_data,
    output logic [RATIO-1:0]         out_keep
);

    localparam int unsigned          IDX_W    = $clog2(RATIO + 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(RATIO - 1);

    localparam logic [0:0] STATE_FILLING = 1'b0;
    localparam logic [0:0] STATE_HOLDING = 1'b1;

    logic [0:0]             state;
    logic [0:0]             state_next;
    logic [IDX_W-1:0]       index;
    logic [IDX_W-1:0]       index_next;
    logic [WIDTH*RATIO-1:0] data_next;
    logic [RATIO-1:0]       keep_next;
    logic                   drain;
    logic                   pop;
    logic                   complete;
    logic                   flush_take;

    assign out_valid = (state == STATE_HOLDING);

    always_comb begin
        drain            = out_valid & out_ready;
        fifo_read_enable = !reset & !fifo_empty & (!out_valid | drain);
        pop              = fifo_read_enable;
        complete         = pop && (index == IDX_LAST);

        // Flush only acts while filling and only if at least one word is
        // already captured (index != 0) or is being popped right now.
        flush_take = flush && (state == STATE_FILLING) && ((index != '0) || pop);

        // A drained packet clears every slot; index is 0 while holding, so a
        // pop in the drain cycle lands in slot 0 of the fresh packet.
        data_next = drain ? '0 : out_data;
        keep_next = drain ? '0 : out_keep;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (pop && (index == IDX_W'(i))) begin
                data_next[i*WIDTH +: WIDTH] = fifo_read_data;
                keep_next[i]                = 1'b1;
            end
        end

        state_next = state;
        index_next = index;
        if (complete || flush_take) begin
            state_next = STATE_HOLDING;
            index_next = '0;
        end else begin
            if (drain) begin
                state_next = STATE_FILLING;
            end
            if (pop) begin
                index_next = index + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= STATE_FILLING;
            index    <= '0;
            out_data <= '0;
            out_keep <= '0;
        end else begin
            state    <= state_next;
            index    <= index_next;
            out_data <= data_next;
            out_keep <= keep_next;
        end
    end

endmodule

// File: tb/tb_fifo_read_packer.sv
// Testbench for fifo_read_packer (WIDTH=8, RATIO=4).
// A small array FIFO model feeds the DUT; inputs change on the falling edge
// and outputs are sampled 1 time unit later.
module tb_fifo_read_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic        fifo_read_enable;
    logic [7:0]  fifo_read_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;

    int checks = 0;
    int errors = 0;
    int pop_count = 0;

    logic [7:0]  mem [0:255];
    logic [31:0] wr_ptr = 0;
    logic [31:0] rd_ptr = 0;

    assign fifo_empty     = (wr_ptr == rd_ptr);
    assign fifo_read_data = mem[rd_ptr[7:0]];

    always #5 clock = ~clock;

    fifo_read_packer #(.WIDTH(8), .RATIO(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .fifo_read_data   (fifo_read_data),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_keep         (out_keep)
    );

    // FIFO model: consume on a pop, flag any pop from an empty FIFO.
    always @(posedge clock) begin
        if (fifo_read_enable) begin
            if (fifo_empty) begin
                errors++;
                $display("FAIL underflow at %0t: fifo_read_enable=1 with fifo_empty=1", $time);
            end else begin
                rd_ptr    <= rd_ptr + 1;
                pop_count <= pop_count + 1;
            end
        end
    end

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[7:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        push;
        logic [7:0]  pdata;
        logic        flush;
        logic        ready;
        logic        e_rd;
        logic        e_valid;
        logic [31:0] e_data;
        logic [3:0]  e_keep;
    } vec_t;

    vec_t vecs [24];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        logic [31:0] exp_word;
        logic        exp_rd;
        logic        exp_valid;

        // push pdata flush ready | rd valid data keep
        // single packet 11..44
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000011, 4'h1};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00002211, 4'h3};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00332211, 4'h7};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44332211, 4'hF};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0};
        // flush with empty FIFO after A1,A2; then flush with nothing captured
        vecs[6]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0};
        vecs[7]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000A1, 4'h1};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000A2A1, 4'h3};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000A2A1, 4'h3};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0};
        // flush coincident with 3rd pop
        vecs[12] = '{1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0};
        vecs[13] = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000B1, 4'h1};
        vecs[14] = '{1'b1, 8'hB3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000B2B1, 4'h3};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00B3B2B1, 4'h7};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00B3B2B1, 4'h7};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0};
        // flush coincident with 4th pop
        vecs[18] = '{1'b1, 8'hC1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0};
        vecs[19] = '{1'b1, 8'hC2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000C1, 4'h1};
        vecs[20] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000C2C1, 4'h3};
        vecs[21] = '{1'b1, 8'hC4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00C3C2C1, 4'h7};
        vecs[22] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'hC4C3C2C1, 4'hF};
        vecs[23] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0};

        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check("reset_rd_en", {31'b0, fifo_read_enable}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_valid", {31'b0, out_valid}, 32'h0);
        check("reset_data", out_data, 32'h0);
        check("reset_keep", {28'b0, out_keep}, 32'h0);

        // Table-driven single-packet / flush sequences
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            if (vecs[i].push) push(vecs[i].pdata);
            flush     = vecs[i].flush;
            out_ready = vecs[i].ready;
            #1;
            check($sformatf("vec%0d_rd_en", i), {31'b0, fifo_read_enable}, {31'b0, vecs[i].e_rd});
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("vec%0d_data", i), out_data, vecs[i].e_data);
            check($sformatf("vec%0d_keep", i), {28'b0, out_keep}, {28'b0, vecs[i].e_keep});
        end
        check("table_pop_count", pop_count, 13);

        // Continuous stream 01..0C, ready held high
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            if (k == 0) begin
                for (int w = 1; w <= 12; w++) push(8'(w));
            end
            #1;
            exp_rd    = (k < 12);
            exp_valid = (k == 4) || (k == 8) || (k == 12);
            check($sformatf("stream%0d_rd_en", k), {31'b0, fifo_read_enable}, {31'b0, exp_rd});
            check($sformatf("stream%0d_valid", k), {31'b0, out_valid}, {31'b0, exp_valid});
            if (exp_valid) begin
                exp_word = {8'(k), 8'(k - 1), 8'(k - 2), 8'(k - 3)};
                check($sformatf("stream%0d_data", k), out_data, exp_word);
                check($sformatf("stream%0d_keep", k), {28'b0, out_keep}, 32'hF);
            end
        end

        // Backpressure: packet 21..24 stalls 5 cycles while 25..27 wait
        pc = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            if (k == 0) begin
                for (int w = 0; w < 7; w++) push(8'h21 + 8'(w));
            end
            out_ready = (k >= 9);
            flush     = (k == 12);
            #1;
            if (k < 4) begin
                check($sformatf("bp%0d_rd_en", k), {31'b0, fifo_read_enable}, 32'h1);
                check($sformatf("bp%0d_valid", k), {31'b0, out_valid}, 32'h0);
            end else if (k < 10) begin
                check($sformatf("bp%0d_rd_en", k), {31'b0, fifo_read_enable}, (k == 9) ? 32'h1 : 32'h0);
                check($sformatf("bp%0d_valid", k), {31'b0, out_valid}, 32'h1);
                check($sformatf("bp%0d_data", k), out_data, 32'h24232221);
                check($sformatf("bp%0d_keep", k), {28'b0, out_keep}, 32'hF);
                if (k == 4) pc = pop_count;
                if (k == 9) check("bp_no_pop_in_stall", pop_count, pc);
            end else if (k == 10) begin
                check("bp10_valid", {31'b0, out_valid}, 32'h0);
                check("bp10_data", out_data, 32'h00000025);
                check("bp10_keep", {28'b0, out_keep}, 32'h1);
            end else if (k == 12) begin
                check("bp12_rd_en", {31'b0, fifo_read_enable}, 32'h0);
                check("bp12_data", out_data, 32'h00272625);
            end else if (k == 13) begin
                check("bp13_valid", {31'b0, out_valid}, 32'h1);
                check("bp13_data", out_data, 32'h00272625);
                check("bp13_keep", {28'b0, out_keep}, 32'h7);
            end else if (k == 14) begin
                check("bp14_valid", {31'b0, out_valid}, 32'h0);
            end
        end

        // Reset with a partial packet captured and the FIFO non-empty
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (k == 0) begin
                push(8'hD1);
                push(8'hD2);
            end
            if (k == 2) begin
                push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
            end
            reset = (k == 2);
            #1;
            if (k == 2) begin
                check("rst_pre_data", out_data, 32'h0000D2D1);
                check("rst_rd_en", {31'b0, fifo_read_enable}, 32'h0);
                pc = pop_count;
            end else if (k == 3) begin
                check("rst_no_pop", pop_count, pc);
                check("rst_after_valid", {31'b0, out_valid}, 32'h0);
                check("rst_after_data", out_data, 32'h0);
                check("rst_after_keep", {28'b0, out_keep}, 32'h0);
                check("rst_after_rd_en", {31'b0, fifo_read_enable}, 32'h1);
            end else if (k == 7) begin
                check("rst_pkt_valid", {31'b0, out_valid}, 32'h1);
                check("rst_pkt_data", out_data, 32'hE4E3E2E1);
                check("rst_pkt_keep", {28'b0, out_keep}, 32'hF);
            end
        end

        @(negedge clock);
        #1;
        check("final_idle_valid", {31'b0, out_valid}, 32'h0);
        check("final_fifo_empty", {31'b0, fifo_empty}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
